// File: rtl/traffic_phase_sequencer.sv
// traffic_phase_sequencer: two vehicle groups, three pedestrian groups, all-red clearance,
// latched pedestrian scramble and night flash, timed in ticks of an external strobe.
module traffic_phase_sequencer #(
    parameter int CNT_W       = 8,
    parameter int T_GREEN_A   = 30,
    parameter int T_GREEN_B   = 30,
    parameter int T_YELLOW    = 3,
    parameter int T_ALLRED    = 1,
    parameter int T_PED_WALK  = 15,
    parameter int T_PED_CLEAR = 3,
    parameter int FLASH_HALF  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       ped_req,
    input  logic       night,
    output logic [2:0] veh_a,
    output logic [2:0] veh_b,
    output logic [2:0] ped_a,
    output logic [2:0] ped_b,
    output logic [2:0] ped_x,
    output logic [3:0] phase,
    output logic       ped_pending
);
    typedef enum logic [3:0] {
        ALLRED_A  = 4'd0,
        GREEN_A   = 4'd1,
        YELLOW_A  = 4'd2,
        ALLRED_B  = 4'd3,
        GREEN_B   = 4'd4,
        YELLOW_B  = 4'd5,
        PED_WALK  = 4'd6,
        PED_CLEAR = 4'd7,
        FLASH     = 4'd8
    } state_t;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;
    localparam logic [2:0] OFF = 3'b000;

    localparam logic [CNT_W-1:0] L_GA = CNT_W'(T_GREEN_A - 1);
    localparam logic [CNT_W-1:0] L_GB = CNT_W'(T_GREEN_B - 1);
    localparam logic [CNT_W-1:0] L_Y  = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] L_AR = CNT_W'(T_ALLRED - 1);
    localparam logic [CNT_W-1:0] L_PW = CNT_W'(T_PED_WALK - 1);
    localparam logic [CNT_W-1:0] L_PC = CNT_W'(T_PED_CLEAR - 1);
    localparam logic [CNT_W-1:0] L_FH = CNT_W'(FLASH_HALF - 1);

    state_t           r_state, w_state, w_succ;
    logic [CNT_W-1:0] r_cnt, w_cnt, w_lim;
    logic             r_flash, w_flash, r_ped, w_ped;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ALLRED_A;
            r_cnt   <= '0;
            r_flash <= 1'b0;
            r_ped   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_flash <= w_flash;
            r_ped   <= w_ped;
        end
    end

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_flash = (r_state == FLASH) ? r_flash : 1'b0;
        case (r_state)
            ALLRED_A, ALLRED_B: w_lim = L_AR;
            GREEN_A:            w_lim = L_GA;
            GREEN_B:            w_lim = L_GB;
            YELLOW_A, YELLOW_B: w_lim = L_Y;
            PED_WALK:           w_lim = L_PW;
            PED_CLEAR:          w_lim = L_PC;
            FLASH:              w_lim = L_FH;
            default:            w_lim = '0;
        endcase
        case (r_state)
            ALLRED_A:  w_succ = GREEN_A;
            GREEN_A:   w_succ = YELLOW_A;
            YELLOW_A:  w_succ = ALLRED_B;
            ALLRED_B:  w_succ = GREEN_B;
            GREEN_B:   w_succ = YELLOW_B;
            YELLOW_B:  w_succ = night ? FLASH : (r_ped ? PED_WALK : ALLRED_A);
            PED_WALK:  w_succ = PED_CLEAR;
            PED_CLEAR: w_succ = night ? FLASH : ALLRED_A;
            default:   w_succ = ALLRED_A;
        endcase
        // Illegal codes recover without waiting for a tick
        if (r_state > FLASH) begin
            w_state = ALLRED_A;
            w_cnt   = '0;
        end else if (tick) begin
            if (r_state == FLASH && !night) begin
                w_state = ALLRED_A;
                w_cnt   = '0;
                w_flash = 1'b0;
            end else if (r_cnt == w_lim) begin
                w_cnt = '0;
                if (r_state == FLASH)
                    w_flash = ~r_flash;
                else
                    w_state = w_succ;
            end else begin
                w_cnt = r_cnt + CNT_W'(1);
            end
        end
        w_ped = (w_state == PED_WALK && r_state != PED_WALK) ? 1'b0 :
                (r_state == PED_WALK || r_state == PED_CLEAR) ? r_ped : (r_ped | ped_req);
    end

    always_comb begin
        veh_a = RED;
        veh_b = RED;
        ped_a = RED;
        ped_b = RED;
        ped_x = RED;
        case (r_state)
            GREEN_A:  begin veh_a = GRN; ped_a = GRN; end
            YELLOW_A: begin veh_a = YEL; ped_a = YEL; end
            GREEN_B:  begin veh_b = GRN; ped_b = GRN; end
            YELLOW_B: begin veh_b = YEL; ped_b = YEL; end
            PED_WALK:  begin ped_a = GRN; ped_b = GRN; ped_x = GRN; end
            PED_CLEAR: begin ped_a = YEL; ped_b = YEL; ped_x = YEL; end
            ALLRED_A, ALLRED_B: ;
            FLASH: begin
                veh_a = r_flash ? OFF : YEL;
                veh_b = r_flash ? OFF : YEL;
                ped_a = OFF;
                ped_b = OFF;
                ped_x = OFF;
            end
            default: begin
                veh_a = OFF;
                veh_b = OFF;
                ped_a = OFF;
                ped_b = OFF;
                ped_x = OFF;
            end
        endcase
    end

    assign phase       = r_state;
    assign ped_pending = r_ped;
endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// tb_traffic_phase_sequencer: directed checks of phase timing, pedestrian latch, night flash,
// tick freeze, async reset, and a long-green/short-yellow parameter override.
module tb_traffic_phase_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rst2 = 1'b1;
    logic       tick = 1'b0;
    logic       ped_req = 1'b0;
    logic       night = 1'b0;
    logic [2:0] veh_a, veh_b, ped_a, ped_b, ped_x;
    logic [3:0] phase;
    logic       ped_pending;
    logic [2:0] veh_a2, veh_b2, ped_a2, ped_b2, ped_x2;
    logic [3:0] phase2;
    logic       ped_pending2;
    int         n_chk = 0;
    int         n_err = 0;
    int         greens;

    always #5 clk = ~clk;

    traffic_phase_sequencer dut (
        .clk(clk), .rst(rst), .tick(tick), .ped_req(ped_req), .night(night),
        .veh_a(veh_a), .veh_b(veh_b), .ped_a(ped_a), .ped_b(ped_b), .ped_x(ped_x),
        .phase(phase), .ped_pending(ped_pending)
    );

    traffic_phase_sequencer #(.CNT_W(8), .T_GREEN_A(255), .T_YELLOW(1)) dut2 (
        .clk(clk), .rst(rst2), .tick(tick), .ped_req(ped_req), .night(night),
        .veh_a(veh_a2), .veh_b(veh_b2), .ped_a(ped_a2), .ped_b(ped_b2), .ped_x(ped_x2),
        .phase(phase2), .ped_pending(ped_pending2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Default cycle: ALLRED_A 1, GREEN_A 30, YELLOW_A 3, ALLRED_B 1, GREEN_B 30, YELLOW_B 3
    function automatic int exp_phase(input int n);
        int m;
        m = n % 68;
        return (m < 1) ? 0 : (m < 31) ? 1 : (m < 34) ? 2 : (m < 35) ? 3 : (m < 65) ? 4 : 5;
    endfunction

    always @(negedge clk)
        if (!rst && phase != 4'd8)
            chk("veh_safety", {31'd0, veh_a != 3'b100 && veh_b != 3'b100}, 32'd0);

    initial begin
        run(2);
        chk("rst_phase", phase, 0);
        chk("rst_veh_a", veh_a, 3'b100);
        chk("rst_ped_x", ped_x, 3'b100);
        chk("rst_pending", ped_pending, 0);
        rst = 1'b0;
        tick = 1'b1;
        greens = 0;
        for (int n = 1; n <= 68; n++) begin
            step();
            chk("seq_phase", phase, exp_phase(n));
            if (veh_a == 3'b001) greens++;
            if (n == 1) chk("ga_ped_a", ped_a, 3'b001);
            if (n == 31) chk("ya_veh_a", veh_a, 3'b010);
            if (n == 35) chk("gb_ped_b", ped_b, 3'b001);
        end
        chk("green_a_ticks", greens, 30);

        run(1);
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        chk("ped_latched", ped_pending, 1);
        run(65);
        chk("yb_before_walk", phase, 5);
        run(1);
        chk("walk_phase", phase, 6);
        chk("walk_pending_clr", ped_pending, 0);
        chk("walk_ped_x", ped_x, 3'b001);
        chk("walk_veh_a", veh_a, 3'b100);
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        chk("walk_ignore_req", ped_pending, 0);
        run(13);
        chk("walk_last", phase, 6);
        run(1);
        chk("clear_phase", phase, 7);
        chk("clear_ped_x", ped_x, 3'b010);
        run(2);
        chk("clear_last", phase, 7);
        run(1);
        chk("after_clear", phase, 0);
        run(68);
        chk("walk_skipped", phase, 0);

        run(1);
        night = 1'b1;
        run(29);
        chk("night_green_holds", phase, 1);
        run(1);
        chk("night_yellow", phase, 2);
        run(36);
        chk("night_yb", phase, 5);
        run(1);
        chk("flash_phase", phase, 8);
        chk("flash_veh_a_on", veh_a, 3'b010);
        chk("flash_veh_b_on", veh_b, 3'b010);
        chk("flash_ped_a", ped_a, 3'b000);
        chk("flash_ped_x", ped_x, 3'b000);
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        chk("flash_veh_a_off", veh_a, 3'b000);
        chk("flash_ped_held", ped_pending, 1);
        run(1);
        chk("flash_veh_a_on2", veh_a, 3'b010);
        night = 1'b0;
        run(1);
        chk("flash_exit", phase, 0);
        chk("flash_exit_veh_a", veh_a, 3'b100);
        chk("flash_exit_pending", ped_pending, 1);

        run(35);
        chk("freeze_start", phase, 4);
        tick = 1'b0;
        run(100);
        chk("freeze_phase", phase, 4);
        chk("freeze_veh_b", veh_b, 3'b001);
        tick = 1'b1;
        run(33);
        chk("served_after_flash", phase, 6);
        run(18);
        chk("served_done", phase, 0);
        run(32);
        chk("mid_yellow", phase, 2);
        rst = 1'b1;
        #1;
        chk("async_phase", phase, 0);
        chk("async_veh_a", veh_a, 3'b100);
        chk("async_ped_a", ped_a, 3'b100);
        step();
        rst = 1'b0;
        chk("restart_allred", phase, 0);
        run(1);
        chk("restart_green", phase, 1);

        rst2 = 1'b0;
        run(1);
        chk("ovr_green", phase2, 1);
        run(254);
        chk("ovr_green_last", phase2, 1);
        chk("ovr_green_lamp", veh_a2, 3'b001);
        run(1);
        chk("ovr_yellow", phase2, 2);
        run(1);
        chk("ovr_yellow_1tick", phase2, 3);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/traffic_phase_sequencer.md
Name: traffic_phase_sequencer

Overview:
- Parametrised successor to the fixed-timing intersection controller; drives two vehicle groups and three pedestrian groups from one Moore FSM.
- Phase durations are parameters counted in ticks of an external enable (e.g. 1 Hz strobe), not raw clk cycles.
- Adds over the previous generation: all-red clearance, on-demand pedestrian scramble phase (latched button), and night flashing mode entered and left only at safe points.

Parameters:
- CNT_W, 8, width of the phase tick counter; every T_* must satisfy 1 <= T_* <= 2^CNT_W
- T_GREEN_A, 30, ticks of vehicle group A green
- T_GREEN_B, 30, ticks of vehicle group B green
- T_YELLOW, 3, ticks of any vehicle yellow
- T_ALLRED, 1, ticks of all-red clearance before each green
- T_PED_WALK, 15, ticks of scramble walk
- T_PED_CLEAR, 3, ticks of pedestrian clearance
- FLASH_HALF, 1, ticks per half-period of the night flash

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- tick  in  1  one-clk strobe; the only event that advances timing
- ped_req  in  1  pedestrian button, level or pulse, sampled every clk
- night  in  1  night-mode request level
- veh_a  out  3  vehicle group A lamp (100 red, 010 yellow, 001 green, 000 dark)
- veh_b  out  3  vehicle group B lamp
- ped_a  out  3  pedestrians parallel to A, same encoding
- ped_b  out  3  pedestrians parallel to B
- ped_x  out  3  diagonal/scramble pedestrians
- phase  out  4  current state code (list order below, 0..8)
- ped_pending  out  1  latched pedestrian request

Behaviour:
- States: ALLRED_A(0), GREEN_A(1), YELLOW_A(2), ALLRED_B(3), GREEN_B(4), YELLOW_B(5), PED_WALK(6), PED_CLEAR(7), FLASH(8).
- Timing: counter is 0 on state entry; on tick, if counter == T-1 the FSM transitions and counter returns to 0, else counter increments. A state lasts exactly T ticks. No tick means nothing changes.
- Sequence: ALLRED_A -> GREEN_A -> YELLOW_A -> ALLRED_B -> GREEN_B -> YELLOW_B -> decision.
- Decision at the end of YELLOW_B:
  - night=1: go to FLASH.
  - else ped_pending=1: go to PED_WALK.
  - else: go to ALLRED_A.
- PED_WALK -> PED_CLEAR. At the end of PED_CLEAR: night=1 goes to FLASH, else ALLRED_A.
- FLASH: exit on the first tick with night=0, going to ALLRED_A with counter 0. night is ignored in every state other than these decision points.
- Outputs are Moore decodes of the state registers, with zero clk latency after a state change. Any lamp not listed below shows red.
  - GREEN_A: veh_a=001, ped_a=001.
  - YELLOW_A: veh_a=010, ped_a=010.
  - GREEN_B: veh_b=001, ped_b=001.
  - YELLOW_B: veh_b=010, ped_b=010.
  - PED_WALK: ped_a, ped_b and ped_x = 001.
  - PED_CLEAR: ped_a, ped_b and ped_x = 010.
  - ALLRED_A, ALLRED_B: all lamps red.
  - FLASH: veh_a and veh_b alternate 010/000; all ped outputs 000.
- Flash toggle: a flash bit is cleared on FLASH entry (lamps show 010 first) and toggles every FLASH_HALF ticks.
- Pedestrian latch:
  - ped_pending sets on any clk with ped_req=1.
  - It clears on the clk that enters PED_WALK.
  - ped_req is ignored during PED_WALK and PED_CLEAR and on the entry clk.
  - The latch is held through FLASH and served after exit.
- Safety invariant: veh_a and veh_b are never simultaneously non-red except during FLASH. ped_x is 001 only in PED_WALK.
- Reset: asynchronous; state=ALLRED_A, counter=0, ped_pending=0, flash bit=0. All outputs are red (100) and phase=0 while rst is high.
- Reset mid-phase aborts immediately; no yellow is completed.
- Illegal state codes (9..15) decode to all lamps 000 and return to ALLRED_A on the next clk.

Test Plan:
- Defaults, tick every clk, ped_req=0, night=0 → phase sequence 0,1,2,3,4,5,0 with dwell 1,30,3,1,30,3 ticks; veh_a=001 exactly 30 ticks.
- Pulse ped_req for one clk during GREEN_A → ped_pending=1; after YELLOW_B enter PED_WALK for 15 ticks with ped_x=001, then PED_CLEAR 3 ticks; ped_pending=0 from the PED_WALK entry clk.
- Pulse ped_req during PED_WALK → ped_pending stays 0; the next cycle skips PED_WALK.
- Raise night during GREEN_A → green and yellow finish normally; FLASH entered after YELLOW_B; veh_a toggles 010,000 each tick with peds 000. Drop night → ALLRED_A on the next tick.
- tick held low for 100 clks in GREEN_B → phase and outputs frozen. Assert rst mid-YELLOW_A → all outputs 100 and phase=0 immediately; the sequence restarts with a 1-tick ALLRED_A.
- Override T_YELLOW=1, T_GREEN_A=255, CNT_W=8 → yellow lasts 1 tick and green lasts 255 ticks with no counter wrap.
